// File: rtl/fifo_dma_writer.sv
// fifo_dma_writer
//   Drains a 1-cycle-latency FIFO and writes each word to memory through a
//   valid/ready write port. Memory is used as a circular buffer of RING_WORDS
//   words starting at BASE_ADDR. Only one word is in flight at a time, so the
//   fastest rate is 3 cycles per word.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   enable       1 = keep draining; 0 = finish the current word, then idle
//   fifo_rdata   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO read strobe, one cycle per word
//   mem_wvalid   write beat valid; mem_wready accepts it
//   mem_waddr    byte address of the beat (BASE_ADDR + word_idx*WIDTH/8)
//   mem_wdata    beat data
//   mem_wlast    last beat of a BURST_LEN-beat burst
//   busy         high whenever the FSM is not idle
//   wrap_irq     one-cycle pulse after the ring's last word is written
//                (present only when FIFO_DMA_WRAP_IRQ_EN is defined)
//
// Build option: FIFO_DMA_WRAP_IRQ_EN adds the wrap_irq output.
module fifo_dma_writer #(
    parameter int unsigned       WIDTH      = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       RING_WORDS = 256,
    parameter int unsigned       BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WIDTH-1:0]  fifo_rdata,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_wlast,
`ifdef FIFO_DMA_WRAP_IRQ_EN
    output logic              wrap_irq,
`endif
    output logic              busy
);

    localparam int unsigned BYTES  = WIDTH / 8;
    localparam int unsigned IDX_W  = (RING_WORDS > 1) ? $clog2(RING_WORDS) : 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RING_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR      = 2'd3
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    word_idx_q;
    logic [IDX_W-1:0]    word_idx_d;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [BEAT_W-1:0]   beat_cnt_d;
    logic [ADDR_W-1:0]   waddr_d;
    logic                more_c;

    // Next counter values and the address of the following word.
    // word_idx wraps naturally because RING_WORDS is a power of two.
    always_comb begin
        more_c     = enable && !fifo_empty;
        word_idx_d = word_idx_q + IDX_W'(1);
        beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
        waddr_d    = BASE_ADDR + ADDR_W'(word_idx_d) * ADDR_W'(BYTES);
    end

    // FSM with registered outputs; each output is set on entry to the state
    // in which it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            beat_cnt_q <= '0;
            fifo_rd_en <= 1'b0;
            mem_wvalid <= 1'b0;
            mem_waddr  <= BASE_ADDR;
            mem_wdata  <= '0;
            mem_wlast  <= 1'b0;
            busy       <= 1'b0;
`ifdef FIFO_DMA_WRAP_IRQ_EN
            wrap_irq   <= 1'b0;
`endif
        end else begin
`ifdef FIFO_DMA_WRAP_IRQ_EN
            wrap_irq <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (more_c) begin
                        state_q    <= RD_REQ;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                RD_REQ: begin
                    // The read is already committed; enable only matters in WR.
                    state_q    <= RD_WAIT;
                    fifo_rd_en <= 1'b0;
                end
                RD_WAIT: begin
                    state_q    <= WR;
                    mem_wdata  <= fifo_rdata;
                    mem_wvalid <= 1'b1;
                    mem_wlast  <= (beat_cnt_q == LAST_BEAT);
                end
                WR: begin
                    // Outputs simply hold while mem_wready is low.
                    if (mem_wready) begin
                        mem_wvalid <= 1'b0;
                        mem_wlast  <= 1'b0;
                        word_idx_q <= word_idx_d;
                        beat_cnt_q <= beat_cnt_d;
                        mem_waddr  <= waddr_d;
`ifdef FIFO_DMA_WRAP_IRQ_EN
                        wrap_irq   <= (word_idx_q == LAST_IDX);
`endif
                        if (more_c) begin
                            state_q    <= RD_REQ;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef FIFO_DMA_WRAP_IRQ_EN
    // Without the wrap interrupt, the ring's last index has no consumer.
    logic unused_last_idx;
    assign unused_last_idx = ^LAST_IDX;
`endif

endmodule
